// File: rtl/systolic_result_deskew.sv
// Re-aligns the skewed per-row partial sums of the systolic array into whole vectors
// and buffers them in a first-word-fall-through FIFO with a valid/ready output.
module systolic_result_deskew #(
  parameter int PARTIAL_SUM_BW = 19,
  parameter int NUM_PE_ROWS    = 8,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    flush,
  input  logic                                    in_valid,
  input  logic [NUM_PE_ROWS*PARTIAL_SUM_BW-1:0]   result,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [NUM_PE_ROWS*PARTIAL_SUM_BW-1:0]   out_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]         count,
  output logic                                    full,
  output logic                                    overflow
);

  localparam int BW   = PARTIAL_SUM_BW;
  localparam int N    = NUM_PE_ROWS;
  localparam int VW   = N * BW;
  localparam int PTRW = $clog2(FIFO_DEPTH);
  localparam int CNTW = $clog2(FIFO_DEPTH + 1);

  logic [N-2:0]      vld_q, vld_d;
  logic [VW-1:0]     alignedVec;
  logic              wvalid;
  logic              pop;
  logic              wrEn;

  logic [VW-1:0]     mem_q [FIFO_DEPTH];
  logic [PTRW-1:0]   wrPtr_q, wrPtr_d;
  logic [PTRW-1:0]   rdPtr_q, rdPtr_d;
  logic [CNTW-1:0]   count_q, count_d;
  logic              overflow_q, overflow_d;

  // Lane i is held back N-1-i cycles so every lane of a vector lines up with the last lane.
  for (genvar i = 0; i < N - 1; i++) begin : g_lane
    localparam int D = N - 1 - i;
    logic [BW-1:0] laneDly_q [D];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k < D; k++) laneDly_q[k] <= '0;
      end else begin
        laneDly_q[0] <= result[i*BW +: BW];
        for (int k = 1; k < D; k++) laneDly_q[k] <= laneDly_q[k-1];
      end
    end

    assign alignedVec[i*BW +: BW] = laneDly_q[D-1];
  end

  assign alignedVec[(N-1)*BW +: BW] = result[(N-1)*BW +: BW];

  assign wvalid    = vld_q[N-2];
  assign out_valid = (count_q != '0);
  assign full      = (count_q == CNTW'(FIFO_DEPTH));
  assign pop       = out_valid & out_ready;
  assign wrEn      = wvalid & (~full | pop);

  always_comb begin
    vld_d      = vld_q << 1;
    vld_d[0]   = in_valid;
    wrPtr_d    = wrPtr_q + PTRW'(wrEn);
    rdPtr_d    = rdPtr_q + PTRW'(pop);
    count_d    = count_q;
    overflow_d = overflow_q | (wvalid & full & ~pop);
    case ({wrEn, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (flush) begin
      vld_d      = '0;
      wrPtr_d    = '0;
      rdPtr_d    = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q      <= '0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      vld_q      <= vld_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is never cleared; the output mask below hides stale entries while empty.
  always_ff @(posedge clk) begin
    if (wrEn && !flush) mem_q[wrPtr_q] <= alignedVec;
  end

  assign out_data = out_valid ? mem_q[rdPtr_q] : '0;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_systolic_result_deskew.sv
// Directed bench for systolic_result_deskew: skews whole vectors onto the result bus
// and checks alignment, FIFO ordering, overflow, flush, reset and empty behaviour.
module tb_systolic_result_deskew;

  localparam int BW = 19;
  localparam int N  = 8;
  localparam int D  = 4;
  localparam int VW = N * BW;
  localparam logic [BW-1:0] JUNK = 19'h2AAAA;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic [VW-1:0] result;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] out_data;
  logic [2:0]    count;
  logic          full;
  logic          overflow;

  int checks   = 0;
  int failures = 0;

  logic [VW-1:0] histVec [N];
  logic          histVld [N];
  logic [VW-1:0] vecA [1:6];
  logic [VW-1:0] vecNeg;

  systolic_result_deskew #(
    .PARTIAL_SUM_BW(BW),
    .NUM_PE_ROWS   (N),
    .FIFO_DEPTH    (D)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .result   (result),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .count    (count),
    .full     (full),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] mkVec(input int base);
    logic [VW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*BW +: BW] = BW'(base + i);
    return v;
  endfunction

  // Lane i of the bus carries the vector injected i cycles earlier, junk when none was.
  task automatic applyStimulus(input logic v, input logic [VW-1:0] vec);
    for (int k = N - 1; k > 0; k--) begin
      histVec[k] = histVec[k-1];
      histVld[k] = histVld[k-1];
    end
    histVec[0] = vec;
    histVld[0] = v;
    for (int i = 0; i < N; i++)
      result[i*BW +: BW] = histVld[i] ? histVec[i][i*BW +: BW] : JUNK;
    in_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) applyStimulus(1'b0, '0);
  endtask

  task automatic checkOutput(input string tag, input logic [VW-1:0] observed,
                             input logic [VW-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; result = '0;
    for (int k = 0; k < N; k++) begin
      histVec[k] = '0;
      histVld[k] = 1'b0;
    end
    for (int k = 1; k <= 6; k++) vecA[k] = mkVec(1000 * k);
    for (int i = 0; i < N; i++) vecNeg[i*BW +: BW] = (i % 2 == 0) ? 19'h7FFFF : 19'h40000;

    #12;
    checkOutput("reset_out_valid", VW'(out_valid), '0);
    checkOutput("reset_count", VW'(count), '0);
    checkOutput("reset_full", VW'(full), '0);
    checkOutput("reset_overflow", VW'(overflow), '0);
    checkOutput("reset_out_data", out_data, '0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] single vector");
    applyStimulus(1'b1, mkVec(100));
    idle(6);
    checkOutput("single_not_yet_valid", VW'(out_valid), '0);
    idle(1);
    checkOutput("single_out_valid", VW'(out_valid), 1);
    checkOutput("single_count", VW'(count), 1);
    checkOutput("single_data", out_data, mkVec(100));
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    checkOutput("single_pop_count", VW'(count), '0);
    checkOutput("single_pop_valid", VW'(out_valid), '0);

    $display("[TB] negative sums");
    applyStimulus(1'b1, vecNeg);
    idle(7);
    checkOutput("neg_data", out_data, vecNeg);
    checkOutput("neg_lane0", VW'(out_data[0 +: BW]), VW'(19'h7FFFF));
    checkOutput("neg_lane1", VW'(out_data[BW +: BW]), VW'(19'h40000));
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;

    $display("[TB] streaming with overflow");
    for (int k = 1; k <= 6; k++) applyStimulus(1'b1, vecA[k]);
    idle(5);
    checkOutput("stream_count_4", VW'(count), 4);
    checkOutput("stream_full", VW'(full), 1);
    checkOutput("stream_no_overflow_yet", VW'(overflow), '0);
    idle(1);
    checkOutput("stream_overflow_set", VW'(overflow), 1);
    idle(2);
    checkOutput("stream_count_held", VW'(count), 4);
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      checkOutput($sformatf("stream_drain_%0d", k), out_data, vecA[k]);
      idle(1);
    end
    out_ready = 1'b0;
    checkOutput("stream_drained_count", VW'(count), '0);
    checkOutput("stream_overflow_sticky", VW'(overflow), 1);
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    checkOutput("flush_clears_overflow", VW'(overflow), '0);

    $display("[TB] simultaneous write and pop while full");
    for (int k = 1; k <= 4; k++) applyStimulus(1'b1, mkVec(5000 + 100 * k));
    idle(7);
    checkOutput("simul_fill_count", VW'(count), 4);
    applyStimulus(1'b1, mkVec(5500));
    idle(6);
    out_ready = 1'b1;
    checkOutput("simul_head", out_data, mkVec(5100));
    idle(1);
    out_ready = 1'b0;
    checkOutput("simul_count", VW'(count), 4);
    checkOutput("simul_no_overflow", VW'(overflow), '0);
    checkOutput("simul_full", VW'(full), 1);
    out_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      checkOutput($sformatf("simul_order_%0d", k), out_data, mkVec(5000 + 100 * k));
      idle(1);
    end
    out_ready = 1'b0;
    checkOutput("simul_empty", VW'(count), '0);

    $display("[TB] flush with vectors in flight");
    for (int k = 1; k <= 5; k++) applyStimulus(1'b1, mkVec(7000 + 100 * k));
    idle(4);
    checkOutput("flush_pre_count", VW'(count), 2);
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    checkOutput("flush_count", VW'(count), '0);
    checkOutput("flush_out_valid", VW'(out_valid), '0);
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      idle(1);
      checkOutput($sformatf("flush_never_emit_%0d", c), VW'(out_valid), '0);
    end
    out_ready = 1'b0;

    $display("[TB] reset with vectors in flight");
    for (int k = 1; k <= 5; k++) applyStimulus(1'b1, mkVec(9000 + 100 * k));
    idle(4);
    checkOutput("rst_pre_count", VW'(count), 2);
    rst = 1'b1;
    #2;
    checkOutput("rst_async_count", VW'(count), '0);
    checkOutput("rst_async_valid", VW'(out_valid), '0);
    checkOutput("rst_async_data", out_data, '0);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      idle(1);
      checkOutput($sformatf("rst_never_emit_%0d", c), VW'(out_valid), '0);
    end

    $display("[TB] empty pop");
    for (int c = 0; c < 20; c++) begin
      idle(1);
      checkOutput($sformatf("empty_valid_%0d", c), VW'(out_valid), '0);
      checkOutput($sformatf("empty_count_%0d", c), VW'(count), '0);
      checkOutput($sformatf("empty_data_%0d", c), out_data, '0);
    end
    out_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
